pe_rx_sink: RTL and testbench
=============================

Name: pe_rx_sink

Overview:
- Ejection-side endpoint of a PE: consumes flits delivered by its router's local output port (data_r2p/valid_r2p) and drives the full back-pressure to that port.
- Buffers flits, checks destination and per-source sequence, and measures latency min/max/sum.
- Counts received flits against a programmed task size and raises task_receive_finish_flag.
- One instance per mesh node, alongside the PE's injector.

Parameters:
- MY_ID, 3'd0, node ID this sink answers to.
- FIFO_DEPTH, 4, ingress FIFO entries (power of 2, ≥4).
- FULL_SLACK, 1, free entries remaining when full asserts.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- data_r2p  in  `DATA_WIDTH (32)  flit from router local port
- valid_r2p  in  1  flit valid
- full  out  1  back-pressure to router local port
- enable  in  1  sink running
- flush  in  1  sync clear of counters/flags/FIFO
- receive_num  in  8  flits expected for the task
- ts_now  in  8  free-running global timestamp
- task_receive_finish_flag  out  1  sticky, task complete
- rx_count  out  8  flits accepted and retired
- seq_err_flag  out  8  per-source sticky sequence-gap flag
- misroute_cnt  out  8  flits with dst≠MY_ID, saturating
- latency_min  out  8  minimum latency
- latency_max  out  8  maximum latency
- latency_sum  out  16  saturating latency sum

Behaviour:
- Flit format:
  - [31:29] dst
  - [28:26] src
  - [25:18] seq
  - [17:10] inject timestamp
  - [9:0] payload
- Reset values: full=0, finish=0, rx_count=0, seq_err_flag=0, misroute_cnt=0, latency_min=8'hFF, latency_max=0, latency_sum=0, FIFO empty, expected seq[0..7]=0, state IDLE.
- Ingress (push):
  - Push when valid_r2p=1 and FIFO not physically full.
  - valid_r2p while physically full: flit dropped, overflow sticky bit set (internal, visible in the bench).
  - full registered: full=1 when count ≥ FIFO_DEPTH−FULL_SLACK, evaluated after this cycle's push/pop.
- FSM states IDLE, RUN, DONE:
  - IDLE→RUN when enable=1.
  - RUN→DONE when retire makes rx_count==receive_num.
  - receive_num=0: RUN→DONE on the first RUN cycle.
  - DONE→IDLE on flush.
  - enable=0 in RUN→IDLE, counters held.
  - Pops occur only in RUN and DONE. In IDLE the FIFO fills and full back-pressures the router.
  - In DONE, flits are still popped and checked but rx_count saturates at 8'hFF.
- Retire pipeline, two stages:
  - S0: pop head.
  - S1 (registered): update stats.
  - Statistics visible 2 cycles after the pop.
  - Push and pop in the same cycle: count unchanged.
- Checks in S1:
  - dst≠MY_ID: misroute_cnt++ (saturate at 255). Flit not counted in rx_count or latency.
  - Otherwise rx_count++.
  - seq≠exp[src]: seq_err_flag[src]=1. In both cases exp[src]=seq+1, mod 256 wrap (255→0 is not an error).
  - lat = ts_now − ts, mod 256.
  - min = min(min, lat); max = max(max, lat).
  - sum += lat, saturating at 16'hFFFF.
- task_receive_finish_flag=1 in DONE, registered, one cycle after the transition.
- flush, highest priority, synchronous:
  - Clears FIFO, pipeline, counters and flags.
  - Restores min to 8'hFF and exp[] to 0.
  - Returns to IDLE.
  - A flit arriving with flush is discarded.
- Async reset mid-transfer: immediate return to reset values; any in-flight flit is lost.

Optional Feature:
- Macro: RX_PAYLOAD_CHECK_EN.
- Defined:
  - S1 compares payload with {src, seq[6:0]}.
  - Mismatch increments a saturating 8-bit payload_err_cnt output port, reset 0, cleared by flush.
- Undefined: port and logic absent; payload ignored.

Decomposition:
- Shared package noc_pkg holds:
  - flit_t packed struct (dst, src, seq, ts, payload)
  - NODE_ID_W=3, SEQ_W=8, TS_W=8
  - rx_state_e {IDLE, RUN, DONE}
- One sub-module: rx_fifo (parameterised sync FIFO with count, push/pop, overflow flag).

Test Plan:
- Reset, enable=1, receive_num=3. Router sends 3 flits to MY_ID=0 from src 2: seq 0,1,2; ts 10; ts_now 15.
  → rx_count=3, min=max=5, sum=15, finish=1, seq_err_flag=0.
- enable=0, 4 back-to-back flits (DEPTH=4, SLACK=1).
  → full=1 after 3rd push. 5th flit while physically full is dropped with overflow set. enable=1 drains 4.
- src 5 sends seq 0 then 2.
  → seq_err_flag=8'b0010_0000. Next seq 3 gives no further error. Wrap 255→0 gives no error.
- Flit with dst=3 into MY_ID=0.
  → misroute_cnt=1; rx_count and latency unchanged.
- ts=250, ts_now=4 → lat=10. Sum saturation: 300 flits at lat 255 → sum=16'hFFFF.
- flush asserted in DONE while valid_r2p=1.
  → all outputs back to reset values next cycle; state IDLE; arriving flit discarded.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC types for the PE ejection endpoint: flit layout, field widths and sink FSM states.
package noc_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NODE_ID_W  = 3;
  localparam int SEQ_W      = 8;
  localparam int TS_W       = 8;
  localparam int PAYLOAD_W  = DATA_WIDTH - 2 * NODE_ID_W - SEQ_W - TS_W;

  typedef struct packed {
    logic [NODE_ID_W-1:0] dst;
    logic [NODE_ID_W-1:0] src;
    logic [SEQ_W-1:0]     seq;
    logic [TS_W-1:0]      ts;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } rx_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pe_rx_sink_fifo.sv
// Synchronous ingress FIFO (module rx_fifo) with occupancy count and a sticky overflow flag
// that records any push attempted while physically full.
module rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_pushData,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_popData,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full,
  output logic                       o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             w_pushAcc;
  logic             w_popAcc;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_popData  = r_mem[r_rdPtr];
  assign o_overflow = r_overflow;
  assign w_pushAcc  = i_push && !o_full;
  assign w_popAcc   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (i_clear) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pushAcc) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_popAcc)  r_rdPtr <= r_rdPtr + AW'(1);
      r_count <= r_count + CW'(w_pushAcc) - CW'(w_popAcc);
      if (i_push && o_full) r_overflow <= 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_pushAcc && !i_clear) r_mem[r_wrPtr] <= i_pushData;
  end

endmodule

// File: rtl/pe_rx_sink.sv
// PE ejection sink: buffers router flits, checks dst/sequence, tracks latency and task completion.
// Optional payload check enabled by defining RX_PAYLOAD_CHECK_EN (adds payload_err_cnt port).
module pe_rx_sink
  import noc_pkg::*;
#(
  parameter logic [2:0] MY_ID      = 3'd0,
  parameter int         FIFO_DEPTH = 4,
  parameter int         FULL_SLACK = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_r2p,
  input  logic                  valid_r2p,
  output logic                  full,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [7:0]            receive_num,
  input  logic [7:0]            ts_now,
  output logic                  task_receive_finish_flag,
  output logic [7:0]            rx_count,
  output logic [7:0]            seq_err_flag,
  output logic [7:0]            misroute_cnt,
  output logic [7:0]            latency_min,
  output logic [7:0]            latency_max,
  output logic [15:0]           latency_sum
`ifdef RX_PAYLOAD_CHECK_EN
  ,
  output logic [7:0]            payload_err_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_TH = CW'(FIFO_DEPTH - FULL_SLACK);

  rx_state_e             r_state, w_nextState;
  logic                  r_full, r_finish, r_s1Valid;
  flit_t                 r_s1Flit;
  logic [7:0]            r_rxCount, r_seqErr, r_misroute, r_latMin, r_latMax;
  logic [15:0]           r_latSum;
  logic [SEQ_W-1:0]      r_expSeq [8];
  logic [DATA_WIDTH-1:0] w_head;
  logic [CW-1:0]         w_fifoCount, w_countNext;
  logic                  w_fifoEmpty, w_fifoFull, w_unusedOverflow;
  logic                  w_pushReq, w_pushAcc, w_pop;
  logic                  w_dstOk, w_retire;
  logic [7:0]            w_lat, w_rxNext;
  logic [16:0]           w_sumExt;

  // A flit arriving together with flush is discarded rather than queued.
  assign w_pushReq   = valid_r2p && !flush;
  assign w_pushAcc   = w_pushReq && !w_fifoFull;
  assign w_pop       = ((r_state == RUN) || (r_state == DONE)) && !w_fifoEmpty && !flush;
  assign w_countNext = w_fifoCount + CW'(w_pushAcc) - CW'(w_pop);

  rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (flush),
    .i_push    (w_pushReq),
    .i_pushData(data_r2p),
    .i_pop     (w_pop),
    .o_popData (w_head),
    .o_count   (w_fifoCount),
    .o_empty   (w_fifoEmpty),
    .o_full    (w_fifoFull),
    .o_overflow(w_unusedOverflow)
  );

  assign w_dstOk  = (r_s1Flit.dst == MY_ID);
  assign w_retire = r_s1Valid && w_dstOk;
  assign w_lat    = ts_now - r_s1Flit.ts;
  assign w_sumExt = {1'b0, r_latSum} + {9'b0, w_lat};
  assign w_rxNext = w_retire ? sat_inc8(r_rxCount) : r_rxCount;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (enable) w_nextState = RUN;
      RUN: begin
        if (!enable)                       w_nextState = IDLE;
        else if (w_rxNext == receive_num)  w_nextState = DONE;
      end
      DONE:    w_nextState = DONE;
      default: w_nextState = IDLE;
    endcase
    if (flush) w_nextState = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_full   <= 1'b0;
      r_finish <= 1'b0;
    end else if (flush) begin
      r_state  <= IDLE;
      r_full   <= 1'b0;
      r_finish <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_full   <= (w_countNext >= FULL_TH);
      r_finish <= r_finish || (r_state == DONE);
    end
  end

  // S0 pops the head into S1; S1 applies all checks and statistics on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Flit  <= '0;
    end else if (flush) begin
      r_s1Valid <= 1'b0;
    end else begin
      r_s1Valid <= w_pop;
      if (w_pop) r_s1Flit <= w_head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxCount  <= '0;
      r_seqErr   <= '0;
      r_misroute <= '0;
      r_latMin   <= 8'hFF;
      r_latMax   <= '0;
      r_latSum   <= '0;
      for (int i = 0; i < 8; i++) r_expSeq[i] <= '0;
    end else if (flush) begin
      r_rxCount  <= '0;
      r_seqErr   <= '0;
      r_misroute <= '0;
      r_latMin   <= 8'hFF;
      r_latMax   <= '0;
      r_latSum   <= '0;
      for (int i = 0; i < 8; i++) r_expSeq[i] <= '0;
    end else if (r_s1Valid) begin
      if (!w_dstOk) begin
        r_misroute <= sat_inc8(r_misroute);
      end else begin
        r_rxCount <= w_rxNext;
        if (w_lat < r_latMin) r_latMin <= w_lat;
        if (w_lat > r_latMax) r_latMax <= w_lat;
        r_latSum <= w_sumExt[16] ? 16'hFFFF : w_sumExt[15:0];
      end
      if (r_s1Flit.seq != r_expSeq[r_s1Flit.src]) r_seqErr[r_s1Flit.src] <= 1'b1;
      r_expSeq[r_s1Flit.src] <= r_s1Flit.seq + 8'd1;
    end
  end

`ifdef RX_PAYLOAD_CHECK_EN
  logic [7:0] r_payloadErrCnt;
  logic       w_payloadOk;

  assign w_payloadOk     = (r_s1Flit.payload == {r_s1Flit.src, r_s1Flit.seq[6:0]});
  assign payload_err_cnt = r_payloadErrCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_payloadErrCnt <= '0;
    else if (flush)                     r_payloadErrCnt <= '0;
    else if (r_s1Valid && !w_payloadOk) r_payloadErrCnt <= sat_inc8(r_payloadErrCnt);
  end
`else
  logic [PAYLOAD_W-1:0] w_unusedPayload;
  assign w_unusedPayload = r_s1Flit.payload;
`endif

  assign full                     = r_full;
  assign task_receive_finish_flag = r_finish;
  assign rx_count                 = r_rxCount;
  assign seq_err_flag             = r_seqErr;
  assign misroute_cnt             = r_misroute;
  assign latency_min              = r_latMin;
  assign latency_max              = r_latMax;
  assign latency_sum              = r_latSum;

endmodule

// File: tb/tb_pe_rx_sink.sv
// Scoreboard bench for pe_rx_sink: a reference model predicts per-flit statistics at drive time
// and a monitor compares them as each flit leaves the retire stage.
module tb_pe_rx_sink;
  import noc_pkg::*;

  localparam logic [2:0] MY_ID = 3'd0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] data_r2p = '0;
  logic        valid_r2p = 1'b0;
  logic        full;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  receive_num = '0;
  logic [7:0]  ts_now = '0;
  logic        task_receive_finish_flag;
  logic [7:0]  rx_count, seq_err_flag, misroute_cnt, latency_min, latency_max;
  logic [15:0] latency_sum;
`ifdef RX_PAYLOAD_CHECK_EN
  logic [7:0]  payload_err_cnt;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  rx;
    logic [7:0]  mis;
    logic [7:0]  seqErr;
    logic [7:0]  lmin;
    logic [7:0]  lmax;
    logic [15:0] sum;
    logic [7:0]  payErr;
  } snap_t;

  snap_t      sbQ[$];
  logic [7:0] mRx, mMis, mSeqErr, mMin, mMax, mPayErr;
  int         mSum;
  logic [7:0] mExp [8];
  bit         checkPending = 1'b0;

  pe_rx_sink #(.MY_ID(MY_ID), .FIFO_DEPTH(4), .FULL_SLACK(1)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .data_r2p                (data_r2p),
    .valid_r2p               (valid_r2p),
    .full                    (full),
    .enable                  (enable),
    .flush                   (flush),
    .receive_num             (receive_num),
    .ts_now                  (ts_now),
    .task_receive_finish_flag(task_receive_finish_flag),
    .rx_count                (rx_count),
    .seq_err_flag            (seq_err_flag),
    .misroute_cnt            (misroute_cnt),
    .latency_min             (latency_min),
    .latency_max             (latency_max),
    .latency_sum             (latency_sum)
`ifdef RX_PAYLOAD_CHECK_EN
    ,
    .payload_err_cnt         (payload_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] makeFlit(input logic [2:0] dst, input logic [2:0] src,
                                            input logic [7:0] seq, input logic [7:0] ts);
    return {dst, src, seq, ts, src, seq[6:0]};
  endfunction

  task automatic modelReset();
    mRx = '0; mMis = '0; mSeqErr = '0; mMin = 8'hFF; mMax = '0; mSum = 0; mPayErr = '0;
    for (int i = 0; i < 8; i++) mExp[i] = '0;
    sbQ.delete();
  endtask

  task automatic modelFlit(input logic [31:0] f);
    flit_t      fl;
    snap_t      s;
    logic [7:0] lat;
    fl  = f;
    lat = ts_now - fl.ts;
    if (fl.dst != MY_ID) begin
      mMis = (mMis == 8'hFF) ? mMis : mMis + 8'd1;
    end else begin
      mRx = (mRx == 8'hFF) ? mRx : mRx + 8'd1;
      if (lat < mMin) mMin = lat;
      if (lat > mMax) mMax = lat;
      mSum = (mSum + int'(lat) > 65535) ? 65535 : mSum + int'(lat);
    end
    if (fl.seq != mExp[fl.src]) mSeqErr[fl.src] = 1'b1;
    mExp[fl.src] = fl.seq + 8'd1;
    if (fl.payload != {fl.src, fl.seq[6:0]}) mPayErr = (mPayErr == 8'hFF) ? mPayErr : mPayErr + 8'd1;
    s.rx = mRx; s.mis = mMis; s.seqErr = mSeqErr; s.lmin = mMin; s.lmax = mMax;
    s.sum = mSum[15:0]; s.payErr = mPayErr;
    sbQ.push_back(s);
  endtask

  // Drives one flit for one cycle; expectAccept says whether the bench predicts a push.
  task automatic applyStimulus(input logic [31:0] f, input bit expectAccept);
    data_r2p  = f;
    valid_r2p = 1'b1;
    if (expectAccept) modelFlit(f);
    @(posedge clk);
    #1;
    valid_r2p = 1'b0;
  endtask

  task automatic sendFlow(input logic [31:0] f);
    int n = 0;
    while (full && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (full) checkOutput("fullTimeout", 32'(full), 32'd0);
    else      applyStimulus(f, 1'b1);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbQ.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sbQ.size() != 0) begin
      checkOutput("drainTimeout", 32'(sbQ.size()), 32'd0);
      sbQ.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic doFlush(input bit withFlit, input logic [31:0] f, input logic en);
    @(posedge clk);
    #1;
    flush     = 1'b1;
    enable    = en;
    valid_r2p = withFlit;
    data_r2p  = f;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    valid_r2p = 1'b0;
    modelReset();
  endtask

  // Retire monitor: S1 occupied at this negedge means stats change on the next posedge.
  always @(negedge clk) begin : monBlk
    snap_t s;
    if (checkPending) begin
      if (sbQ.size() == 0) begin
        checkOutput("sbUnderflow", 32'd1, 32'd0);
      end else begin
        s = sbQ.pop_front();
        checkOutput("rxCount", 32'(rx_count), 32'(s.rx));
        checkOutput("misroute", 32'(misroute_cnt), 32'(s.mis));
        checkOutput("seqErr", 32'(seq_err_flag), 32'(s.seqErr));
        checkOutput("latMin", 32'(latency_min), 32'(s.lmin));
        checkOutput("latMax", 32'(latency_max), 32'(s.lmax));
        checkOutput("latSum", 32'(latency_sum), 32'(s.sum));
`ifdef RX_PAYLOAD_CHECK_EN
        checkOutput("payErr", 32'(payload_err_cnt), 32'(s.payErr));
`endif
      end
    end
    checkPending = rst_n && dut.r_s1Valid && !flush;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    modelReset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstFull", 32'(full), 32'd0);
    checkOutput("rstFinish", 32'(task_receive_finish_flag), 32'd0);
    checkOutput("rstRx", 32'(rx_count), 32'd0);
    checkOutput("rstSeqErr", 32'(seq_err_flag), 32'd0);
    checkOutput("rstMis", 32'(misroute_cnt), 32'd0);
    checkOutput("rstMin", 32'(latency_min), 32'hFF);
    checkOutput("rstMax", 32'(latency_max), 32'd0);
    checkOutput("rstSum", 32'(latency_sum), 32'd0);
    checkOutput("rstState", 32'(dut.r_state), 32'(IDLE));

    $display("[TB] basic task of 3 flits");
    ts_now = 8'd15; receive_num = 8'd3; enable = 1'b1;
    for (int i = 0; i < 3; i++) sendFlow(makeFlit(3'd0, 3'd2, 8'(i), 8'd10));
    waitDrain();
    checkOutput("t1Finish", 32'(task_receive_finish_flag), 32'd1);
    checkOutput("t1Rx", 32'(rx_count), 32'd3);
    checkOutput("t1Min", 32'(latency_min), 32'd5);
    checkOutput("t1Max", 32'(latency_max), 32'd5);
    checkOutput("t1Sum", 32'(latency_sum), 32'd15);
    checkOutput("t1SeqErr", 32'(seq_err_flag), 32'd0);

    $display("[TB] flush in DONE with arriving flit");
    checkOutput("t6PreState", 32'(dut.r_state), 32'(DONE));
    doFlush(1'b1, makeFlit(3'd0, 3'd2, 8'd3, 8'd10), 1'b0);
    checkOutput("t6Finish", 32'(task_receive_finish_flag), 32'd0);
    checkOutput("t6Rx", 32'(rx_count), 32'd0);
    checkOutput("t6Min", 32'(latency_min), 32'hFF);
    checkOutput("t6Max", 32'(latency_max), 32'd0);
    checkOutput("t6Sum", 32'(latency_sum), 32'd0);
    checkOutput("t6State", 32'(dut.r_state), 32'(IDLE));
    checkOutput("t6FifoCnt", 32'(dut.u_fifo.r_count), 32'd0);
    @(negedge clk);
    checkOutput("t6FifoCntLater", 32'(dut.u_fifo.r_count), 32'd0);

    $display("[TB] back-pressure while idle");
    ts_now = 8'd20; receive_num = 8'd4;
    applyStimulus(makeFlit(3'd0, 3'd1, 8'd0, 8'd12), 1'b1);
    applyStimulus(makeFlit(3'd0, 3'd1, 8'd1, 8'd12), 1'b1);
    checkOutput("t2FullAt2", 32'(full), 32'd0);
    applyStimulus(makeFlit(3'd0, 3'd1, 8'd2, 8'd12), 1'b1);
    checkOutput("t2FullAt3", 32'(full), 32'd1);
    applyStimulus(makeFlit(3'd0, 3'd1, 8'd3, 8'd12), 1'b1);
    checkOutput("t2OvfAt4", 32'(dut.u_fifo.r_overflow), 32'd0);
    checkOutput("t2CntAt4", 32'(dut.u_fifo.r_count), 32'd4);
    applyStimulus(makeFlit(3'd0, 3'd1, 8'd4, 8'd12), 1'b0);
    checkOutput("t2OvfAt5", 32'(dut.u_fifo.r_overflow), 32'd1);
    checkOutput("t2CntAt5", 32'(dut.u_fifo.r_count), 32'd4);
    enable = 1'b1;
    waitDrain();
    checkOutput("t2FullDrained", 32'(full), 32'd0);
    checkOutput("t2Rx", 32'(rx_count), 32'd4);
    checkOutput("t2Finish", 32'(task_receive_finish_flag), 32'd1);

    $display("[TB] sequence gap from src 5");
    sendFlow(makeFlit(3'd0, 3'd5, 8'd0, 8'd12));
    sendFlow(makeFlit(3'd0, 3'd5, 8'd2, 8'd12));
    waitDrain();
    checkOutput("t3SeqGap", 32'(seq_err_flag), 32'h20);
    sendFlow(makeFlit(3'd0, 3'd5, 8'd3, 8'd12));
    waitDrain();
    checkOutput("t3SeqResync", 32'(seq_err_flag), 32'h20);

    $display("[TB] misrouted flit");
    sendFlow(makeFlit(3'd3, 3'd6, 8'd0, 8'd12));
    waitDrain();
    checkOutput("t4Mis", 32'(misroute_cnt), 32'd1);
    checkOutput("t4Rx", 32'(rx_count), 32'd7);
    checkOutput("t4Max", 32'(latency_max), 32'd8);

    $display("[TB] timestamp wrap");
    ts_now = 8'd4;
    sendFlow(makeFlit(3'd0, 3'd2, 8'd0, 8'd250));
    waitDrain();
    checkOutput("t5Max", 32'(latency_max), 32'd10);
    checkOutput("t5Min", 32'(latency_min), 32'd8);

    $display("[TB] sum saturation and seq wrap");
    doFlush(1'b0, 32'd0, 1'b1);
    ts_now = 8'd0; receive_num = 8'd200;
    for (int i = 0; i < 300; i++) sendFlow(makeFlit(3'd0, 3'd4, 8'(i), 8'd1));
    waitDrain();
    checkOutput("t7Sum", 32'(latency_sum), 32'hFFFF);
    checkOutput("t7Min", 32'(latency_min), 32'hFF);
    checkOutput("t7Max", 32'(latency_max), 32'hFF);
    checkOutput("t7SeqErr", 32'(seq_err_flag), 32'd0);
    checkOutput("t7Rx", 32'(rx_count), 32'hFF);
    checkOutput("t7Finish", 32'(task_receive_finish_flag), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
